csa_accum_pipe: RTL and testbench
=================================

// Module: csa_accum_pipe
// PURPOSE
//  Multi-operand carry-save accumulator. Each beat carries NUM_OPS operands. The beat is reduced by a
//  generate-built 3:2 (fulladder) tree, together with the running carry-save pair (acc_s, acc_c).
//  A final carry-propagate add resolves the pair only at packet end. Sits after the tree_N_M /
//  adder_N_M compressors as the sequential, streaming, arbitrary-operand-count generalisation.
// PARAMETERS
//  WIDTH    8   width of each input operand
//  NUM_OPS  7   operands per beat, legal 1..16
//  ACC_W    16  accumulator/result width, ACC_W >= WIDTH
//  CNT_W    8   width of beat counter output
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  in_valid   in   1              beat valid
//  in_ready   out  1              beat accepted when in_valid & in_ready
//  in_data    in   NUM_OPS*WIDTH  operand k at [k*WIDTH +: WIDTH]
//  in_last    in   1              final beat of packet
//  out_valid  out  1              result valid
//  out_ready  in   1              result consumed when out_valid & out_ready
//  out_sum    out  ACC_W          packet sum, modulo 2^ACC_W
//  out_cnt    out  CNT_W          beats in packet, saturates at 2^CNT_W-1
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is asynchronous and active-low.
//  - Reset values: state=ACCUM; acc_s, acc_c, out_sum, beat_cnt = 0; out_valid = 0.
//    in_ready follows state, so it reads 1 once reset is released.
//  - FSM states:
//    ACCUM:   in_ready=1. On each accepted beat, the NUM_OPS+2 rows (extended operands + acc_s + acc_c)
//             reduce to 2 rows, which are registered into acc_s/acc_c. beat_cnt increments.
//             If in_last is set on that beat -> RESOLVE.
//    RESOLVE: in_ready=0. Registers out_sum <= acc_s+acc_c (ACC_W CPA) and out_cnt <= beat_cnt.
//             Sets out_valid=1 and clears acc_s/acc_c/beat_cnt -> HOLD.
//    HOLD:    in_ready=0. out_sum/out_cnt stable. On out_ready: out_valid <= 0 -> ACCUM.
//  - Latency and throughput:
//    last beat accepted at edge t; out_valid high after edge t+1.
//    1 beat/clk inside a packet; min 2-clk gap between packets.
//  - Arithmetic:
//    operands are zero-extended to ACC_W. Every 3:2 carry is shifted left 1 and truncated at bit ACC_W-1.
//    All sums are modulo 2^ACC_W; no overflow flag.
//  - Boundaries:
//    in_valid low in ACCUM: acc holds, no count.
//    in_last on the first beat: single-beat packet.
//    out_ready high on the first out_valid cycle: one-cycle pulse, returns to ACCUM next edge.
//    NUM_OPS=1: tree is a single 3:2 layer.
//  - Reset mid-packet: all partial state is discarded immediately. No result is emitted for that packet.
//  - in_data and in_last are ignored unless the beat is accepted.
// CONFIGURATION
//  CSA_SIGNED_EN defined:
//    operands are two's complement and sign-extended to ACC_W.
//    out_sum is a two's-complement ACC_W value.
//  CSA_SIGNED_EN undefined:
//    operands are unsigned and zero-extended.
//    No other behaviour changes in either case.
// TESTING (WIDTH=8, NUM_OPS=7, ACC_W=16 unless noted)
//  T1 single beat, all operands 8'hFF, last=1
//     -> out_valid 2 edges later; out_sum=16'h06F9, out_cnt=1.
//  T2 3 back-to-back beats, operands 1..7 each, last on 3rd
//     -> out_sum=16'd84, out_cnt=3; in_ready=1 on all 3 beats.
//  T3 T2 with in_valid low 4 clks between beats 1 and 2
//     -> out_sum=84, out_cnt=3.
//  T4 T1 with out_ready held low 5 clks
//     -> out_sum stable, in_ready=0 throughout; one transfer on out_ready; next beat accepted 1 clk later.
//  T5 ACC_W=10, T1 stimulus
//     -> out_sum=10'd761 (1785 mod 1024).
//  T6 rst_n pulsed low after 2 beats of a packet, then a T1 packet
//     -> out_valid stays 0 during reset; result 16'h06F9 (no residue).
//     With CSA_SIGNED_EN, T1 stimulus -> out_sum=16'hFFF9 (-7).

Source files
------------

// File: rtl/csa_accum_pipe.sv
// rtl/csa_accum_pipe.sv - streaming multi-operand carry-save accumulator
//
// Purpose:
//   Each accepted beat carries NUM_OPS operands. A chain of 3:2 compressors,
//   built with generate, folds these operands into the running carry-save
//   pair (acc_s, acc_c). A single carry-propagate add resolves the pair only
//   when the packet ends.
//
// Configuration macro:
//   CSA_SIGNED_EN - when defined, operands are two's complement and are
//                   sign-extended to ACC_W. Otherwise they are zero-extended.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_n_i       asynchronous active-low reset
//   in_valid_i    beat valid
//   in_ready_o    beat accepted when in_valid_i & in_ready_o
//   in_data_i     operand k at [k*WIDTH +: WIDTH]
//   in_last_i     final beat of the packet
//   out_valid_o   result valid
//   out_ready_i   result consumed when out_valid_o & out_ready_i
//   out_sum_o     packet sum modulo 2^ACC_W
//   out_cnt_o     beats in the packet, saturating at 2^CNT_W-1

module csa_accum_pipe #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 7,
    parameter int ACC_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_OPS*WIDTH-1:0] in_data_i,
    input  logic                     in_last_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ACC_W-1:0]         out_sum_o,
    output logic [CNT_W-1:0]         out_cnt_o
);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_s_q, acc_s_d;
    logic [ACC_W-1:0]   acc_c_q, acc_c_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_valid_q, out_valid_d;

    // Operands extended to the accumulator width.
    logic [ACC_W-1:0]   ext_op [NUM_OPS];

    // Sum/carry rows after each compressor stage. Stage k absorbs operand k,
    // so the last stage holds the reduced NUM_OPS+2 rows.
    logic [ACC_W-1:0]   lvl_s  [NUM_OPS];
    logic [ACC_W-1:0]   lvl_c  [NUM_OPS];

    genvar k;
    generate
        for (k = 0; k < NUM_OPS; k++) begin : g_ext
`ifdef CSA_SIGNED_EN
            assign ext_op[k] = ACC_W'($signed(in_data_i[k*WIDTH +: WIDTH]));
`else
            assign ext_op[k] = ACC_W'(in_data_i[k*WIDTH +: WIDTH]);
`endif
        end

        for (k = 0; k < NUM_OPS; k++) begin : g_csa
            logic [ACC_W-1:0] row_a;
            logic [ACC_W-1:0] row_b;
            if (k == 0) begin : g_first
                // First layer compresses the stored pair with operand 0.
                assign row_a = acc_s_q;
                assign row_b = acc_c_q;
            end else begin : g_next
                assign row_a = lvl_s[k-1];
                assign row_b = lvl_c[k-1];
            end
            assign lvl_s[k] = row_a ^ row_b ^ ext_op[k];
            // Carry moves up one weight; the bit leaving ACC_W is dropped,
            // which keeps every partial sum modulo 2^ACC_W.
            assign lvl_c[k] = ((row_a & row_b) | (row_a & ext_op[k]) |
                               (row_b & ext_op[k])) << 1;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        beat_cnt_d  = beat_cnt_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;
        in_ready_o  = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    acc_s_d = lvl_s[NUM_OPS-1];
                    acc_c_d = lvl_c[NUM_OPS-1];
                    if (beat_cnt_q != {CNT_W{1'b1}}) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    if (in_last_i) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                // The only carry-propagate add in the design.
                out_sum_d   = acc_s_q + acc_c_q;
                out_cnt_d   = beat_cnt_q;
                out_valid_d = 1'b1;
                acc_s_d     = '0;
                acc_c_d     = '0;
                beat_cnt_d  = '0;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_ACCUM;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            beat_cnt_q  <= '0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            beat_cnt_q  <= beat_cnt_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign out_cnt_o   = out_cnt_q;

endmodule

// File: tb/tb_csa_accum_pipe.sv
// tb/tb_csa_accum_pipe.sv - self-checking bench for csa_accum_pipe

module tb_csa_accum_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic [55:0] in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_sum;
    logic [7:0]  out_cnt;

    logic        in_ready10;
    logic        out_valid10;
    logic [9:0]  out_sum10;
    logic [7:0]  out_cnt10;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    csa_accum_pipe #(.WIDTH(8), .NUM_OPS(7), .ACC_W(16), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_cnt_o   (out_cnt)
    );

    csa_accum_pipe #(.WIDTH(8), .NUM_OPS(7), .ACC_W(10), .CNT_W(8)) dut10 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready10),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid10),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum10),
        .out_cnt_o   (out_cnt10)
    );

    typedef struct {
        logic [7:0]  base;
        bit          incr;
        int          nbeats;
        int          gap;
        int          hold;
        logic [15:0] exp_sum;
        logic [9:0]  exp_sum10;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [8];

`ifdef CSA_SIGNED_EN
    localparam logic [15:0] SUM_FF1   = 16'hFFF9;
    localparam logic [9:0]  SUM10_FF1 = 10'h3F9;
    localparam logic [15:0] SUM_80X2  = 16'hF900;
    localparam logic [9:0]  SUM10_80  = 10'd256;
    localparam logic [15:0] SUM_FF40  = 16'hFEE8;
`else
    localparam logic [15:0] SUM_FF1   = 16'h06F9;
    localparam logic [9:0]  SUM10_FF1 = 10'd761;
    localparam logic [15:0] SUM_80X2  = 16'h0700;
    localparam logic [9:0]  SUM10_80  = 10'd768;
    localparam logic [15:0] SUM_FF40  = 16'h16E8;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_packet(input string name, input vec_t v);
        bit ready_ok = 1'b1;
        bit hold_ok  = 1'b1;
        for (int b = 0; b < v.nbeats; b++) begin
            in_valid = 1'b1;
            in_last  = (b == v.nbeats - 1);
            for (int k = 0; k < 7; k++) begin
                in_data[k*8 +: 8] = v.incr ? v.base + 8'(k) : v.base;
            end
            if (!in_ready || !in_ready10) ready_ok = 1'b0;
            step();
            if (b == 0 && v.gap > 0 && v.nbeats > 1) begin
                // Idle cycles with junk that must not be absorbed.
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = {7{8'hAA}};
                for (int g = 0; g < v.gap; g++) step();
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = {7{8'h55}};
        check({name, "_ready_beats"}, 32'(ready_ok), 32'd1);
        check({name, "_valid_early"}, 32'(out_valid), 32'd0);
        step();
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_sum"}, 32'(out_sum), 32'(v.exp_sum));
        check({name, "_cnt"}, 32'(out_cnt), 32'(v.exp_cnt));
        check({name, "_sum10"}, {out_valid10, 21'd0, out_sum10},
              {1'b1, 21'd0, v.exp_sum10});
        for (int h = 0; h < v.hold; h++) begin
            out_ready = 1'b0;
            step();
            if (out_valid !== 1'b1 || out_sum !== v.exp_sum ||
                out_cnt !== 8'(v.exp_cnt) || in_ready !== 1'b0) hold_ok = 1'b0;
        end
        if (v.hold > 0) check({name, "_hold_stable"}, 32'(hold_ok), 32'd1);
        check({name, "_ready_low"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({name, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{8'hFF, 1'b0, 1,   0, 0, SUM_FF1,  SUM10_FF1, 1};
        vecs[1] = '{8'h01, 1'b1, 3,   0, 0, 16'd84,   10'd84,    3};
        vecs[2] = '{8'h01, 1'b1, 3,   4, 0, 16'd84,   10'd84,    3};
        vecs[3] = '{8'hFF, 1'b0, 1,   0, 5, SUM_FF1,  SUM10_FF1, 1};
        vecs[4] = '{8'h80, 1'b0, 2,   0, 0, SUM_80X2, SUM10_80,  2};
        vecs[5] = '{8'hFF, 1'b0, 40,  0, 1, SUM_FF40, 10'd744,   40};
        vecs[6] = '{8'h00, 1'b0, 1,   0, 0, 16'd0,    10'd0,     1};
        vecs[7] = '{8'h01, 1'b1, 300, 0, 0, 16'd8400, 10'd208,   255};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        check("reset_valid_low", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_sum", 32'(out_sum), 32'd0);
        check("reset_cnt", 32'(out_cnt), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_packet($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a packet must discard the partial sum.
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = {7{8'hFF}};
        step();
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_valid_low", 32'(out_valid), 32'd0);
        step();
        step();
        check("midrst_valid_still_low", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check("midrst_valid_after", 32'(out_valid), 32'd0);
        run_packet("post_reset", vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
